// File: rtl/line_cut_rotator.sv
// Ping-pong line buffer that re-emits each BT.656 active line one line later,
// cyclically rotated by a DRBG-derived cut; timing codes ride a 2-clock delay line.
module line_cut_rotator #(
  parameter int unsigned ACTIVE_BYTES = 1440,
  parameter int unsigned CUT_STEP     = 4,
  parameter int unsigned DATA_W       = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] bt_656_in,
  input  logic              H,
  input  logic              V,
  input  logic              enable,
  input  logic [7:0]        cut_in,
  input  logic              cut_valid,
  output logic [DATA_W-1:0] bt_656_out,
  output logic              H_out,
  output logic              V_out,
  output logic [7:0]        cut_used,
  output logic              cut_miss
);

  localparam int unsigned ADDR_W = $clog2(ACTIVE_BYTES + 1);
  localparam logic [ADDR_W-1:0] N_A    = ADDR_W'(ACTIVE_BYTES);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(ACTIVE_BYTES - 1);

  logic              act_c, line_start_c, line_end_c, v_rise_c, wr_en_c, sub_c;
  logic              wr_bank_c, rd_bank_c, line_sub_c;
  logic [ADDR_W-1:0] idx_c, rd_addr_c, off_c;
  logic [7:0]        cut_sel_c;
  logic [31:0]       off_wide_c;

  logic              act_prev_q, act_prev_d, v_prev_q, v_prev_d;
  logic              wr_bank_q, wr_bank_d;
  logic [1:0]        full_q, full_d;
  logic [1:0][7:0]   cut_bank_q, cut_bank_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d, rd_addr_q, rd_addr_d;
  logic              line_sub_q, line_sub_d;
  logic [7:0]        line_cut_q, line_cut_d;
  logic [DATA_W-1:0] d1_q, d1_d;
  logic              h1_q, h1_d, v1_q, v1_d, sub1_q, sub1_d;
  logic              first1_q, first1_d, miss1_q, miss1_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              h_out_q, h_out_d, v_out_q, v_out_d;
  logic [7:0]        cut_used_q, cut_used_d;
  logic              cut_miss_q, cut_miss_d;

  logic [DATA_W-1:0] mem [2][ACTIVE_BYTES];
  logic [DATA_W-1:0] ram_rd_q;

  always_comb begin
    act_c        = !H && !V;
    line_start_c = act_c && !act_prev_q;
    line_end_c   = !act_c && act_prev_q;
    v_rise_c     = V && !v_prev_q;

    // At line start the banks swap: read the bank that was just written.
    wr_bank_c = line_start_c ? !wr_bank_q : wr_bank_q;
    rd_bank_c = !wr_bank_c;
    idx_c     = line_start_c ? '0 : wr_cnt_q;

    cut_sel_c  = cut_bank_q[rd_bank_c];
    off_wide_c = 32'(cut_sel_c) * CUT_STEP;
    if (off_wide_c >= ACTIVE_BYTES) off_wide_c = off_wide_c - ACTIVE_BYTES;
    off_c = ADDR_W'(off_wide_c);

    rd_addr_c  = line_start_c ? off_c : rd_addr_q;
    line_sub_c = line_start_c ? (enable && full_q[rd_bank_c]) : line_sub_q;
    wr_en_c    = act_c && !reset && (idx_c < N_A);
    sub_c      = act_c && line_sub_c && (idx_c < N_A);

    act_prev_d = act_c;
    v_prev_d   = V;
    wr_bank_d  = wr_bank_c;
    line_sub_d = line_sub_c;
    line_cut_d = line_start_c ? cut_sel_c : line_cut_q;
    wr_cnt_d   = wr_cnt_q;
    rd_addr_d  = rd_addr_q;
    full_d     = full_q;
    cut_bank_d = cut_bank_q;

    if (act_c) begin
      wr_cnt_d  = wr_en_c ? idx_c + ADDR_W'(1) : idx_c;
      rd_addr_d = (rd_addr_c == LAST_A) ? '0 : rd_addr_c + ADDR_W'(1);
    end
    if (line_start_c) begin
      full_d[wr_bank_c]     = 1'b0;
      cut_bank_d[wr_bank_c] = cut_valid ? cut_in : 8'd0;
    end
    if (line_end_c) full_d[wr_bank_q] = (wr_cnt_q == N_A);
    // A new field never reuses data from the previous one.
    if (v_rise_c) full_d = '0;

    d1_d     = bt_656_in;
    h1_d     = H;
    v1_d     = V;
    sub1_d   = sub_c;
    first1_d = line_start_c && sub_c;
    miss1_d  = line_start_c && !cut_valid;

    out_d      = sub1_q ? ram_rd_q : d1_q;
    h_out_d    = h1_q;
    v_out_d    = v1_q;
    cut_used_d = (sub1_q && first1_q) ? line_cut_q : cut_used_q;
    cut_miss_d = miss1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      act_prev_q <= 1'b0;
      v_prev_q   <= 1'b1;
      wr_bank_q  <= 1'b0;
      full_q     <= '0;
      cut_bank_q <= '0;
      wr_cnt_q   <= '0;
      rd_addr_q  <= '0;
      line_sub_q <= 1'b0;
      line_cut_q <= '0;
      d1_q       <= '0;
      h1_q       <= 1'b1;
      v1_q       <= 1'b1;
      sub1_q     <= 1'b0;
      first1_q   <= 1'b0;
      miss1_q    <= 1'b0;
      out_q      <= '0;
      h_out_q    <= 1'b1;
      v_out_q    <= 1'b1;
      cut_used_q <= '0;
      cut_miss_q <= 1'b0;
    end else begin
      act_prev_q <= act_prev_d;
      v_prev_q   <= v_prev_d;
      wr_bank_q  <= wr_bank_d;
      full_q     <= full_d;
      cut_bank_q <= cut_bank_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_addr_q  <= rd_addr_d;
      line_sub_q <= line_sub_d;
      line_cut_q <= line_cut_d;
      d1_q       <= d1_d;
      h1_q       <= h1_d;
      v1_q       <= v1_d;
      sub1_q     <= sub1_d;
      first1_q   <= first1_d;
      miss1_q    <= miss1_d;
      out_q      <= out_d;
      h_out_q    <= h_out_d;
      v_out_q    <= v_out_d;
      cut_used_q <= cut_used_d;
      cut_miss_q <= cut_miss_d;
    end
  end

  // Line RAM: read issued alongside the first delay stage.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_bank_c][idx_c] <= bt_656_in;
    ram_rd_q <= mem[rd_bank_c][rd_addr_c];
  end

  assign bt_656_out = out_q;
  assign H_out      = h_out_q;
  assign V_out      = v_out_q;
  assign cut_used   = cut_used_q;
  assign cut_miss   = cut_miss_q;

endmodule

// File: tb/tb_line_cut_rotator.sv
// Randomized bench for line_cut_rotator: a line-level reference model fills a
// scoreboard queue, and a negedge monitor compares every output word.
module tb_line_cut_rotator;

  localparam int N    = 1440;
  localparam int STEP = 4;

  logic       clk = 1'b0;
  logic       reset, H, V, enable, cut_valid;
  logic [9:0] bt_656_in, bt_656_out;
  logic       H_out, V_out, cut_miss;
  logic [7:0] cut_in, cut_used;

  always #5 clk = ~clk;

  line_cut_rotator #(.ACTIVE_BYTES(N), .CUT_STEP(STEP), .DATA_W(10)) dut (
    .clk(clk), .reset(reset), .bt_656_in(bt_656_in), .H(H), .V(V),
    .enable(enable), .cut_in(cut_in), .cut_valid(cut_valid),
    .bt_656_out(bt_656_out), .H_out(H_out), .V_out(V_out),
    .cut_used(cut_used), .cut_miss(cut_miss)
  );

  typedef struct packed {
    logic [9:0] data;
    logic       h;
    logic       v;
    logic [7:0] cu;
    logic       miss;
  } exp_t;

  localparam exp_t RST_E = '{data: 10'd0, h: 1'b1, v: 1'b1, cu: 8'd0, miss: 1'b0};

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state, expressed in lines rather than banks.
  logic [9:0] cur_line[$];
  logic [9:0] fin_line[$];
  logic [9:0] rd_line[$];
  logic [7:0] cur_cut, fin_cut, rd_cut, cu_m;
  bit         fin_valid, in_line, prev_v, sub_en;
  int         k, off;

  task automatic model_reset();
    cur_line.delete();
    fin_valid = 1'b0;
    in_line   = 1'b0;
    prev_v    = 1'b1;
    sub_en    = 1'b0;
    cu_m      = 8'd0;
    cur_cut   = 8'd0;
    fin_cut   = 8'd0;
    k         = 0;
  endtask

  task automatic model_step(input logic [9:0] d, input bit h, input bit v, input bit en,
                            input logic [7:0] cin, input bit cv, input bit rst);
    exp_t e;
    bit   act, ls;
    if (rst) begin
      // Word already in flight when reset hits is lost too.
      if (sb_q.size() > 0) begin
        void'(sb_q.pop_back());
        sb_q.push_back(RST_E);
      end
      model_reset();
      sb_q.push_back(RST_E);
      return;
    end
    act = !h && !v;
    ls  = act && !in_line;
    if (!act && in_line) begin
      fin_line  = cur_line;
      fin_cut   = cur_cut;
      fin_valid = (cur_line.size() == N);
    end
    if (v && !prev_v) fin_valid = 1'b0;
    prev_v = v;
    if (ls) begin
      rd_line = fin_line;
      rd_cut  = fin_cut;
      sub_en  = en && fin_valid;
      off     = int'(fin_cut) * STEP;
      if (off >= N) off -= N;
      cur_line.delete();
      cur_cut = cv ? cin : 8'd0;
      k = 0;
    end
    in_line = act;
    e.data = d;
    e.h    = h;
    e.v    = v;
    e.miss = ls && !cv;
    if (act) begin
      if (sub_en && k < N) begin
        e.data = rd_line[(k + off) % N];
        if (k == 0) cu_m = rd_cut;
      end
      if (cur_line.size() < N) cur_line.push_back(d);
      k++;
    end
    e.cu = cu_m;
    sb_q.push_back(e);
  endtask

  task automatic drive_cycle(input logic [9:0] d, input bit h, input bit v, input bit en,
                             input logic [7:0] cin, input bit cv, input bit rst);
    @(posedge clk);
    #1;
    bt_656_in = d;
    H         = h;
    V         = v;
    enable    = en;
    cut_in    = cin;
    cut_valid = cv;
    reset     = rst;
    model_step(d, h, v, en, cin, cv, rst);
  endtask

  task automatic run_line(input int n_act, input int n_blank, input bit vb, input logic [7:0] cut,
                          input bit cv, input bit en, input bit ramp, input int rst_at,
                          input int v_at);
    for (int i = 0; i < n_blank; i++)
      drive_cycle(10'($urandom), 1'b1, vb, 1'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    for (int i = 0; i < n_act; i++) begin
      logic [9:0] d;
      d = ramp ? 10'((i % 256) << 2) : 10'($urandom);
      if (i == 0)
        drive_cycle(d, 1'b0, vb || (i >= v_at), en, cut, cv, i == rst_at);
      else
        drive_cycle(d, 1'b0, vb || (i >= v_at), 1'($urandom), 8'($urandom), 1'($urandom),
                    i == rst_at);
    end
  endtask

  // Output lags input by two clocks, so the queue holds three entries at each compare.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() >= 3) begin
      e = sb_q.pop_front();
      checks++;
      if (bt_656_out !== e.data || H_out !== e.h || V_out !== e.v ||
          cut_used !== e.cu || cut_miss !== e.miss) begin
        errors++;
        $display("FAIL out_word @%0t: got data=%h H=%b V=%b cut_used=%h miss=%b, expected data=%h H=%b V=%b cut_used=%h miss=%b",
                 $time, bt_656_out, H_out, V_out, cut_used, cut_miss,
                 e.data, e.h, e.v, e.cu, e.miss);
      end
    end
  end

  initial begin
    int n_act, r;
    reset = 1'b1; H = 1'b1; V = 1'b0; enable = 1'b0;
    cut_in = 8'd0; cut_valid = 1'b0; bt_656_in = 10'd0;
    model_reset();
    repeat (4) drive_cycle(10'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
    run_line(0, 12, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, -1, N);

    run_line(N,    16, 1'b0, 8'd1,   1'b1, 1'b1, 1'b1, -1, N);
    run_line(N,    16, 1'b0, 8'hFF,  1'b1, 1'b1, 1'b1, -1, N);
    run_line(N,    16, 1'b0, 8'd0,   1'b1, 1'b1, 1'b0, -1, N);
    run_line(N,    16, 1'b0, 8'd5,   1'b1, 1'b1, 1'b0, -1, N);
    run_line(1000, 16, 1'b0, 8'd7,   1'b1, 1'b1, 1'b0, -1, N);
    run_line(N,    16, 1'b0, 8'd9,   1'b1, 1'b1, 1'b0, -1, N);
    run_line(1500, 16, 1'b0, 8'd3,   1'b1, 1'b1, 1'b0, -1, N);
    run_line(N,    16, 1'b0, 8'd200, 1'b0, 1'b1, 1'b0, -1, N);
    run_line(N,    16, 1'b0, 8'd20,  1'b1, 1'b1, 1'b0, -1, N);
    run_line(N,    16, 1'b0, 8'd11,  1'b1, 1'b1, 1'b0, -1, 700);
    run_line(N,    16, 1'b0, 8'd21,  1'b1, 1'b1, 1'b0, -1, N);
    run_line(300,  16, 1'b1, 8'd30,  1'b1, 1'b1, 1'b0, -1, N);
    run_line(300,  16, 1'b1, 8'd31,  1'b1, 1'b1, 1'b0, -1, N);
    run_line(N,    16, 1'b0, 8'd10,  1'b1, 1'b1, 1'b0, -1, N);
    run_line(N,    16, 1'b0, 8'd12,  1'b1, 1'b1, 1'b0, -1, N);
    run_line(N,    16, 1'b0, 8'd13,  1'b1, 1'b1, 1'b0, 700, N);
    run_line(N,    16, 1'b0, 8'd14,  1'b1, 1'b1, 1'b0, -1, N);
    run_line(N,    16, 1'b0, 8'd15,  1'b1, 1'b1, 1'b0, -1, N);
    run_line(N,    16, 1'b0, 8'd16,  1'b1, 1'b0, 1'b0, -1, N);
    run_line(N,    16, 1'b0, 8'd17,  1'b1, 1'b1, 1'b0, -1, N);

    for (int ln = 0; ln < 14; ln++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6)       n_act = N;
      else if (r < 8)  n_act = int'($urandom_range(200, N - 1));
      else if (r == 8) n_act = int'($urandom_range(N + 1, 1500));
      else             n_act = 300;
      run_line(n_act, int'($urandom_range(4, 20)), r == 9, 8'($urandom),
               $urandom_range(0, 7) != 0, $urandom_range(0, 5) != 0, 1'b0,
               ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 1200)) : -1, N);
    end

    repeat (6) drive_cycle(10'($urandom), 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    if (sb_q.size() > 2) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected at most 2", sb_q.size());
    end
    if (checks < 40000) begin
      errors++;
      $display("FAIL compare_count: got %0d compares, expected at least 40000", checks);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_cut_rotator.md
Name: line_cut_rotator

Overview:
- Video scrambling stage directly downstream of drbg_consumer and sync_parser.
- Buffers each BT.656 active line in a ping-pong line buffer.
- Re-emits the buffered line one line later, cyclically rotated by a cut offset taken from the DRBG byte (data_out / data_out_valid) sampled at the start of that line.
- Timing codes and blanking pass through with the same fixed pipeline delay, so downstream framing is unchanged.

Parameters:
- ACTIVE_BYTES, 1440, bytes per active line (720 px 4:2:2).
- CUT_STEP, 4, bytes per cut unit; keeps Cb-Y-Cr-Y alignment.
- DATA_W, 10, BT.656 word width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- bt_656_in  in  DATA_W  input video word
- H  in  1  horizontal blanking from sync_parser (1 = blanking)
- V  in  1  vertical blanking from sync_parser (1 = blanking)
- enable  in  1  1 = scramble, 0 = transparent (still delayed)
- cut_in  in  8  random byte from drbg_consumer data_out
- cut_valid  in  1  drbg_consumer data_out_valid
- bt_656_out  out  DATA_W  output video word
- H_out  out  1  H delayed to align with bt_656_out
- V_out  out  1  V delayed to align with bt_656_out
- cut_used  out  8  cut value applied to the line now being output
- cut_miss  out  1  one-cycle pulse: line started with cut_valid=0

Behaviour:
- Reset: bt_656_out=0, H_out=1, V_out=1, cut_used=0, cut_miss=0, wr_bank=0, both bank_full flags=0, counters=0. Reset mid-line discards both banks.
- Fixed latency: every output is the input 2 clocks earlier (delay line), except active-video substitution. All outputs are registered.
- Active cycle: H=0 && V=0.
- Line start: first active cycle after any non-active cycle.
- At line start:
  - Latch cut for the bank being written: cut_in if cut_valid, else 0 with cut_miss pulse.
  - Compute off = cut*CUT_STEP; if off >= ACTIVE_BYTES, subtract ACTIVE_BYTES once.
  - Swap banks: the read bank becomes the previous write bank.
  - Reset wr_cnt=0; set rd_addr=off of the read bank.
- Write path: each active cycle, store bt_656_in at wr_cnt in the write bank, then wr_cnt++.
  - wr_cnt saturates at ACTIVE_BYTES; excess bytes are not stored.
  - The bank is marked full only if exactly ACTIVE_BYTES were written.
  - A short line (ended by H or V early) marks the bank not-full.
- Read path: synchronous RAM read issued in the same cycle the input word enters the 2-stage delay.
  - rd_addr increments and wraps to 0 at ACTIVE_BYTES-1. No modulo operator.
  - Output k of the line = stored byte (k+off) mod ACTIVE_BYTES.
- Substitution rule: bt_656_out = RAM data iff the delayed cycle was active, enable=1, read bank full, and delayed output index < ACTIVE_BYTES. Otherwise bt_656_out = delayed input.
- cut_used updates to the read bank's cut at the first substituted output word of each line.
- Vertical blanking: no writes, banks are not swapped.
  - First active line after V falls outputs pass-through, because the read bank was invalidated on V rising.
  - V rising clears both full flags, so no data crosses fields.
- enable=0: writes and cut latching continue; output is pass-through.
  - enable changes take effect only at line start.
- Simultaneous line start and cut_valid=1: that byte is latched.
  - The producer's value updates one cycle later and does not affect this line.

Test Plan:
- Ramp line: active bytes 0..1439 (mod 256, <<2), cut_in=1 valid -> next line outputs original bytes 4,5,...,1439,0,1,2,3; H_out/V_out = H/V delayed 2.
- cut_in=0xFF -> off=1020; first output byte = stored[1020], byte 420 = stored[0]; cut_in=0 -> identity order.
- Short line of 1000 active bytes -> following line is pass-through; long line of 1500 -> bytes 1440..1499 pass through; the next rotated line is intact.
- cut_valid=0 at line start -> cut_miss pulses once, cut_used=0 on that line's output, data unrotated.
- V rise mid-stream then fall -> first active line after V is pass-through; second line is rotated using the cut from the first.
- reset asserted mid-active-line for 1 cycle -> outputs equal reset values next cycle, next line pass-through, rotation resumes on the line after.
